// File: rtl/m_word_fetch_pkg.sv
// Shared constants, FSM encoding and field-width helpers for the ROM word fetchers
// (modulus, exponent and R fetchers all reuse these).
package m_word_fetch_pkg;

  localparam int unsigned M_DATA_WIDTH = 32;
  localparam int unsigned M_ADDR_WIDTH = 7;
  localparam int unsigned M_ROM_RD_LAT = 2;
  localparam int unsigned M_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_FETCH  = 2'd1,
    FETCH_DRAIN  = 2'd2,
    FETCH_FINISH = 2'd3
  } fetch_state_t;

  // Tag = {valid, last, idx}
  function automatic int unsigned fetch_tag_width(input int unsigned aw);
    return aw + 2;
  endfunction

  // FIFO entry = {data, last, idx}
  function automatic int unsigned fetch_entry_width(input int unsigned dw, input int unsigned aw);
    return dw + 1 + aw;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Synchronous skid FIFO with occupancy count and synchronous flush; shared by the
// modulus and exponent fetchers. DEPTH must be a power of 2.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Upstream credit accounting must keep a free slot for every write.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(wr_en && full && !flush));

endmodule

// File: rtl/m_word_fetch.sv
// Modulus ROM word fetcher: issues sequential ROM reads, realigns them with a tag pipe
// and streams words through a credit-limited skid FIFO. Define M_FETCH_REVERSE_EN for
// descending (MSW-first) address order.
module m_word_fetch
  import m_word_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = M_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = M_ADDR_WIDTH,
  parameter int unsigned RD_LAT     = M_ROM_RD_LAT,
  parameter int unsigned FIFO_DEPTH = M_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] out_index
);

  localparam int unsigned TAG_W   = fetch_tag_width(ADDR_WIDTH);
  localparam int unsigned ENTRY_W = fetch_entry_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);
  localparam logic [CRED_W-1:0]   DEPTH_C  = CRED_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  fetch_state_t state, state_nx;

  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [TAG_W-1:0]      tag_pipe [RD_LAT];
  logic [TAG_W-1:0]      cap_tag;

  logic                  kill;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] issue_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CRED_W-1:0]     inflight;
  logic [CRED_W-1:0]     used;
  logic                  tags_empty;
  logic                  capture;
  logic                  pop;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;

  assign cap_tag = tag_pipe[RD_LAT-1];
  assign capture = cap_tag[TAG_W-1] && !kill;
  assign pop     = out_valid && out_ready;

  always_comb begin
    kill       = abort && (state != FETCH_IDLE);
    accept     = (state == FETCH_IDLE) && start && !abort;
    inflight   = '0;
    tags_empty = 1'b1;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CRED_W'(tag_pipe[i][TAG_W-1]);
      if (tag_pipe[i][TAG_W-1]) tags_empty = 1'b0;
    end
    // Words in flight reserve a FIFO slot, so a capture never meets a full FIFO.
    used       = CRED_W'(fifo_count) + inflight;
    issue      = (state == FETCH_FETCH) && (issued_q < count_q) && (used < DEPTH_C) && !kill;
    issue_last = (issued_q == count_q - ONE);
    issue_idx  = ADDR_WIDTH'(issued_q);
`ifdef M_FETCH_REVERSE_EN
    next_addr  = base_q + ADDR_WIDTH'(count_q - issued_q - ONE);
`else
    next_addr  = base_q + ADDR_WIDTH'(issued_q);
`endif

    state_nx = state;
    case (state)
      FETCH_IDLE: begin
        if (accept) state_nx = (word_count == '0) ? FETCH_FINISH : FETCH_FETCH;
      end
      FETCH_FETCH: begin
        if (issued_q == count_q) state_nx = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        // The final word is always the last one in the FIFO, so popping it drains it.
        if (tags_empty && ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop)))
          state_nx = FETCH_FINISH;
      end
      FETCH_FINISH: state_nx = FETCH_IDLE;
      default:      state_nx = FETCH_IDLE;
    endcase
    if (kill) state_nx = FETCH_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      count_q     <= '0;
      issued_q    <= '0;
      base_q      <= '0;
      mem_address <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != FETCH_IDLE);
      done  <= (state == FETCH_FINISH) && !kill;
      if (accept) begin
        count_q  <= word_count;
        base_q   <= base_addr;
        issued_q <= '0;
      end
      if (issue) begin
        mem_address <= next_addr;
        issued_q    <= issued_q + ONE;
      end
      // Tag enters with the mem_address update and leaves as mem_q becomes valid.
      tag_pipe[0] <= issue ? {1'b1, issue_last, issue_idx} : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (kill) begin
        for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      end
    end
  end

  fetch_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (kill),
    .wr_en   (capture),
    .wr_data ({mem_q, cap_tag[TAG_W-2:0]}),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[ENTRY_W-1 -: DATA_WIDTH];
  assign out_last  = fifo_head[ADDR_WIDTH];
  assign out_index = fifo_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_m_word_fetch.sv
// Scoreboard bench for m_word_fetch: a behavioural ROM, a reference model that
// enqueues expected words per burst, and an independent stream monitor.
module tb_m_word_fetch;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int ROM_WORDS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [AW-1:0] out_index;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [DW-1:0] rom [ROM_WORDS];

  int vectors = 0;
  int miscompares = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  bit rand_ready = 1'b0;
  bit addr_known = 1'b1;
  int last_addr = 0;

  m_word_fetch #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LAT     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_q       (mem_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_index   (out_index)
  );

  initial forever #5 clock = ~clock;

  initial for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'hA000_0000 + i;

  // Behavioural ROM output register; mem_address is the other latency stage.
  always @(posedge clock) mem_q <= rom[mem_address];

  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented/handshaken word with the scoreboard head.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got out_data %h index %0d, no word expected (t=%0t)",
                   out_data, out_index, $time);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("word_data", out_data, e.data);
          check("word_last", out_last, e.last);
          check("word_index", out_index, e.idx);
          hs_cnt++;
        end else begin
          check("stall_data", out_data, exp_q[0].data);
          check("stall_last", out_last, exp_q[0].last);
        end
      end
    end
  end

  task automatic push_burst(input int base, input int cnt);
    exp_t x;
    int a;
    for (int k = 0; k < cnt; k++) begin
`ifdef M_FETCH_REVERSE_EN
      a = (base + cnt - 1 - k) % ROM_WORDS;
`else
      a = (base + k) % ROM_WORDS;
`endif
      x.data = rom[a];
      x.last = (k == cnt - 1);
      x.idx  = 7'(k);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic issue_start(input int base, input int cnt);
    @(posedge clock);
    #1;
    start      = 1'b1;
    base_addr  = 7'(base);
    word_count = 8'(cnt);
    push_burst(base, cnt);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // exp_first / exp_done: negedges after the start-sampling edge; -1 skips the check.
  task automatic run_burst(input int base, input int cnt, input int exp_first, input int exp_done);
    int n;
    int first;
    bit got;
    wait_idle();
    issue_start(base, cnt);
    n = 0;
    first = -1;
    got = 1'b0;
    while (!got && n < 5000) begin
      @(negedge clock);
      n++;
      if (n == 1) check("busy_after_start", busy, 1);
      if (out_valid && first < 0) first = n;
      if (done) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles (base %0d count %0d)", n, base, cnt);
      exp_q.delete();
    end else begin
      if (exp_done >= 0) check("done_latency", n, exp_done);
      if (exp_first >= 0) check("first_valid_latency", first, exp_first);
      check("busy_at_done", busy, 0);
      check("words_left_at_done", exp_q.size(), 0);
      if (cnt > 0) begin
`ifdef M_FETCH_REVERSE_EN
        last_addr = base % ROM_WORDS;
`else
        last_addr = (base + cnt - 1) % ROM_WORDS;
`endif
        addr_known = 1'b1;
      end
      if (addr_known) check("mem_address_hold", mem_address, last_addr);
    end
  endtask

  initial begin
    int d0, h0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    reset_n = 1'b1;

    // Deterministic bursts at full throughput
    rand_ready = 1'b0;
    run_burst(0, 8, 4, 13);
    run_burst(126, 4, 4, 9);
    run_burst(50, 0, -1, 2);
    run_burst(4, 4, 4, 9);

    // Randomized back-pressure
    rand_ready = 1'b1;
    run_burst($urandom_range(0, ROM_WORDS - 1), 16, -1, -1);
    for (int r = 0; r < 5; r++)
      run_burst($urandom_range(0, ROM_WORDS - 1), $urandom_range(1, 24), -1, -1);
    run_burst($urandom_range(0, ROM_WORDS - 1), ROM_WORDS, -1, -1);
    run_burst(17, 0, -1, -1);

    // Abort after 5 of 12 words
    rand_ready = 1'b0;
    wait_idle();
    repeat (2) @(posedge clock);
    h0 = hs_cnt;
    issue_start(60, 12);
    repeat (8) @(posedge clock);
    #1;
    check("hs_before_abort", hs_cnt - h0, 5);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    exp_q.delete();
    addr_known = 1'b0;
    @(negedge clock);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (10) @(posedge clock);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    run_burst(0, 3, 4, 8);

    // Asynchronous reset mid-burst
    wait_idle();
    issue_start(40, 10);
    repeat (6) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_mem_address", mem_address, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_index", out_index, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    last_addr = 0;
    addr_known = 1'b1;
    run_burst(9, 0, -1, 2);
    run_burst(5, 3, 4, 8);

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
